rtc_write_sequencer: RTL and testbench

Write-side sequencer for the RTC parallel bus: it snapshots time/date values and walks the RTC through address/data write steps for seconds, minutes, hours, day, month and year, then a transfer command. It pairs with the read sequencer and presents the same step-driven handshake to the shared bus-timing engine, which generates the address-phase, data-phase and step-complete strobes. Its outputs drive the bus mux as the write source.

---
 rtl/rtc_pkg.sv | 47 ++++
 rtl/rtc_bcd_check.sv | 9 +
 rtl/rtc_write_sequencer.sv | 164 ++++++++++++++++
 tb/tb_rtc_write_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared RTC bus definitions: write-sequencer state encoding, step addresses
// and the step-address lookup used by the write sequencer.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEG  = 3'd1,
        ST_MIN  = 3'd2,
        ST_HORA = 3'd3,
        ST_DIA  = 3'd4,
        ST_MES  = 3'd5,
        ST_ANO  = 3'd6,
        ST_CMD  = 3'd7
    } wr_state_e;

    localparam logic [7:0] ADDR_CLK_SEG  = 8'h21;
    localparam logic [7:0] ADDR_CLK_MIN  = 8'h22;
    localparam logic [7:0] ADDR_CLK_HORA = 8'h23;
    localparam logic [7:0] ADDR_CLK_DIA  = 8'h24;
    localparam logic [7:0] ADDR_CLK_MES  = 8'h25;
    localparam logic [7:0] ADDR_CLK_ANO  = 8'h26;

    localparam logic [7:0] ADDR_TMR_SEG  = 8'h41;
    localparam logic [7:0] ADDR_TMR_MIN  = 8'h42;
    localparam logic [7:0] ADDR_TMR_HORA = 8'h43;

    localparam logic [7:0] ADDR_CMD_CLK  = 8'hF1;
    localparam logic [7:0] ADDR_CMD_TMR  = 8'hF2;

    // Timer mode never visits DIA/MES/ANO, so those rows only carry clock addresses.
    function automatic logic [7:0] step_addr(input wr_state_e st, input logic clk_mode);
        logic [7:0] addr;
        addr = 8'h00;
        case (st)
            ST_SEG:  addr = clk_mode ? ADDR_CLK_SEG  : ADDR_TMR_SEG;
            ST_MIN:  addr = clk_mode ? ADDR_CLK_MIN  : ADDR_TMR_MIN;
            ST_HORA: addr = clk_mode ? ADDR_CLK_HORA : ADDR_TMR_HORA;
            ST_DIA:  addr = ADDR_CLK_DIA;
            ST_MES:  addr = ADDR_CLK_MES;
            ST_ANO:  addr = ADDR_CLK_ANO;
            ST_CMD:  addr = clk_mode ? ADDR_CMD_CLK  : ADDR_CMD_TMR;
            default: addr = 8'h00;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// Combinational BCD validity check: both nibbles of the byte must be 0..9.
module rtc_bcd_check (
    input  logic [7:0] value,
    output logic       valid
);

    assign valid = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);

endmodule

// File: rtl/rtc_write_sequencer.sv
// RTC write sequencer: snapshots time/date and steps the bus engine through
// address/data writes. Optional BCD input check under RTC_WR_BCD_CHECK_EN.
module rtc_write_sequencer
    import rtc_pkg::*;
#(
    parameter logic [7:0] IDLE_BUS = 8'hFF,
    parameter logic [7:0] CMD_DATA = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       en_clk,
    input  logic       dir_phase,
    input  logic       dat_phase,
    input  logic       step_done,
    input  logic [7:0] seg_in,
    input  logic [7:0] min_in,
    input  logic [7:0] hora_in,
    input  logic [7:0] dia_in,
    input  logic [7:0] mes_in,
    input  logic [7:0] ano_in,
    output logic [7:0] bus_data,
    output logic       e_write,
    output logic       tr_write,
    output logic       done,
    output logic       err
);

    wr_state_e  state_q, state_d;
    logic       mode_q, mode_d;
    logic [7:0] seg_q, seg_d, min_q, min_d, hora_q, hora_d;
    logic [7:0] dia_q, dia_d, mes_q, mes_d, ano_q, ano_d;
    logic [7:0] bus_data_q, bus_data_d;
    logic       e_write_q, e_write_d;
    logic       tr_write_q, tr_write_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       data_ok;
    logic [7:0] step_data;

`ifdef RTC_WR_BCD_CHECK_EN
    logic [5:0] byte_ok;

    rtc_bcd_check u_chk_seg  (.value(seg_in),  .valid(byte_ok[0]));
    rtc_bcd_check u_chk_min  (.value(min_in),  .valid(byte_ok[1]));
    rtc_bcd_check u_chk_hora (.value(hora_in), .valid(byte_ok[2]));
    rtc_bcd_check u_chk_dia  (.value(dia_in),  .valid(byte_ok[3]));
    rtc_bcd_check u_chk_mes  (.value(mes_in),  .valid(byte_ok[4]));
    rtc_bcd_check u_chk_ano  (.value(ano_in),  .valid(byte_ok[5]));

    // Timer writes never use day/month/year, so their contents must not block it.
    assign data_ok = en_clk ? (&byte_ok) : (&byte_ok[2:0]);
`else
    assign data_ok = 1'b1;
`endif

    always_comb begin
        step_data = 8'h00;
        case (state_q)
            ST_SEG:  step_data = seg_q;
            ST_MIN:  step_data = min_q;
            ST_HORA: step_data = hora_q;
            ST_DIA:  step_data = dia_q;
            ST_MES:  step_data = mes_q;
            ST_ANO:  step_data = ano_q;
            ST_CMD:  step_data = CMD_DATA;
            default: step_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        seg_d      = seg_q;
        min_d      = min_q;
        hora_d     = hora_q;
        dia_d      = dia_q;
        mes_d      = mes_q;
        ano_d      = ano_q;
        bus_data_d = bus_data_q;
        e_write_d  = e_write_q;
        tr_write_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start) begin
                if (data_ok) begin
                    seg_d     = seg_in;
                    min_d     = min_in;
                    hora_d    = hora_in;
                    dia_d     = dia_in;
                    mes_d     = mes_in;
                    ano_d     = ano_in;
                    mode_d    = en_clk;
                    e_write_d = 1'b1;
                    state_d   = ST_SEG;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (dir_phase) begin
            bus_data_d = step_addr(state_q, mode_q);
        end else if (dat_phase) begin
            bus_data_d = step_data;
            tr_write_d = 1'b1;
        end else if (step_done) begin
            case (state_q)
                ST_SEG:  state_d = ST_MIN;
                ST_MIN:  state_d = ST_HORA;
                ST_HORA: state_d = mode_q ? ST_DIA : ST_CMD;
                ST_DIA:  state_d = ST_MES;
                ST_MES:  state_d = ST_ANO;
                ST_ANO:  state_d = ST_CMD;
                ST_CMD: begin
                    state_d    = ST_IDLE;
                    e_write_d  = 1'b0;
                    done_d     = 1'b1;
                    bus_data_d = IDLE_BUS;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            seg_q      <= 8'h00;
            min_q      <= 8'h00;
            hora_q     <= 8'h00;
            dia_q      <= 8'h00;
            mes_q      <= 8'h00;
            ano_q      <= 8'h00;
            bus_data_q <= IDLE_BUS;
            e_write_q  <= 1'b0;
            tr_write_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            seg_q      <= seg_d;
            min_q      <= min_d;
            hora_q     <= hora_d;
            dia_q      <= dia_d;
            mes_q      <= mes_d;
            ano_q      <= ano_d;
            bus_data_q <= bus_data_d;
            e_write_q  <= e_write_d;
            tr_write_q <= tr_write_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus_data = bus_data_q;
    assign e_write  = e_write_q;
    assign tr_write = tr_write_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: scripted and randomized write sequences checked
// against a list-based model of the expected address/data byte stream.
module tb_rtc_write_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, en_clk, dir_phase, dat_phase, step_done;
    logic [7:0] seg_in, min_in, hora_in, dia_in, mes_in, ano_in;
    logic [7:0] bus_data;
    logic       e_write, tr_write, done, err;

    logic [7:0] vals [6];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         done_seen = 0;
    int         done_exp = 0;

    always #5 clk = ~clk;

    rtc_write_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .en_clk(en_clk),
        .dir_phase(dir_phase), .dat_phase(dat_phase), .step_done(step_done),
        .seg_in(seg_in), .min_in(min_in), .hora_in(hora_in),
        .dia_in(dia_in), .mes_in(mes_in), .ano_in(ano_in),
        .bus_data(bus_data), .e_write(e_write), .tr_write(tr_write),
        .done(done), .err(err)
    );

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply strobes for one clock; outputs are observed at the following negedge.
    task automatic tick(input logic d, input logic a, input logic s);
        dir_phase = d;
        dat_phase = a;
        step_done = s;
        @(negedge clk);
    endtask

    task automatic set_vals(input logic [7:0] a, b, c, d, e, f);
        vals[0] = a; vals[1] = b; vals[2] = c;
        vals[3] = d; vals[4] = e; vals[5] = f;
    endtask

    function automatic logic [7:0] rand_bcd();
        logic [3:0] hi, lo;
        hi = 4'($urandom_range(0, 9));
        lo = 4'($urandom_range(0, 9));
        return {hi, lo};
    endfunction

    // Model: the byte stream a write must produce, as (address, data) pairs.
    task automatic build_model(input logic mode);
        int n;
        exp_q.delete();
        n = mode ? 6 : 3;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back((mode ? 8'h20 : 8'h40) + 8'(i + 1));
            exp_q.push_back(vals[i]);
        end
        exp_q.push_back(mode ? 8'hF1 : 8'hF2);
        exp_q.push_back(8'h01);
    endtask

    // abort_at >= 0: assert reset during that step's data phase and stop there.
    task automatic run_seq(input logic mode, input int abort_at);
        int         nsteps;
        logic [7:0] addr, data;
        logic       last;
        build_model(mode);
        nsteps = exp_q.size() / 2;
        seg_in = vals[0]; min_in = vals[1]; hora_in = vals[2];
        dia_in = vals[3]; mes_in = vals[4]; ano_in = vals[5];
        en_clk = mode;
        start  = 1'b1;
        tick(0, 0, 0);
        start = 1'b0;
        check("start_e_write", e_write, 1);
        check("start_bus", bus_data, 8'hFF);
        check("start_err", err, 0);
        check("start_done", done, 0);
        seg_in = 8'($urandom); min_in = 8'($urandom); hora_in = 8'($urandom);
        dia_in = 8'($urandom); mes_in = 8'($urandom); ano_in = 8'($urandom);
        en_clk = 1'($urandom);
        for (int step = 0; step < nsteps; step++) begin
            addr = exp_q.pop_front();
            data = exp_q.pop_front();
            last = (step == nsteps - 1);
            repeat ($urandom_range(0, 2)) begin
                tick(0, 0, 0);
                check("gap_tr", tr_write, 0);
                check("gap_e_write", e_write, 1);
                check("gap_done", done, 0);
            end
            repeat ($urandom_range(1, 2)) begin
                tick(1, 0, 0);
                check("addr", bus_data, addr);
                check("addr_tr", tr_write, 0);
            end
            repeat ($urandom_range(1, 2)) begin
                tick(0, 1, 0);
                check("data", bus_data, data);
                check("data_tr", tr_write, 1);
            end
            if (step == abort_at) begin
                reset = 1'b1;
                #1;
                check("rst_bus", bus_data, 8'hFF);
                check("rst_e_write", e_write, 0);
                check("rst_tr", tr_write, 0);
                tick(0, 0, 0);
                check("rst_hold_bus", bus_data, 8'hFF);
                check("rst_done", done, 0);
                reset = 1'b0;
                tick(0, 0, 0);
                check("post_rst_e_write", e_write, 0);
                check("post_rst_done", done, 0);
                return;
            end
            start = last ? 1'b0 : 1'($urandom_range(0, 1));
            tick(0, 0, 1);
            start = 1'b0;
            check("sd_tr", tr_write, 0);
            check("sd_done", done, last);
            check("sd_e_write", e_write, !last);
            check("sd_bus", bus_data, last ? 8'hFF : data);
        end
        tick(0, 0, 0);
        check("after_done", done, 0);
        check("after_e_write", e_write, 0);
        done_exp++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; en_clk = 1'b0;
        dir_phase = 1'b0; dat_phase = 1'b0; step_done = 1'b0;
        seg_in = 8'h00; min_in = 8'h00; hora_in = 8'h00;
        dia_in = 8'h00; mes_in = 8'h00; ano_in = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_bus", bus_data, 8'hFF);
        check("reset_e_write", e_write, 0);
        check("reset_tr", tr_write, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        reset = 1'b0;
        tick(0, 0, 0);

        set_vals(8'h59, 8'h45, 8'h23, 8'h31, 8'h12, 8'h99);
        run_seq(1'b1, -1);

        set_vals(8'h10, 8'h05, 8'h01, 8'h77, 8'h88, 8'h66);
        run_seq(1'b0, -1);

        // Abort during the MES data phase (step index 4).
        set_vals(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
        run_seq(1'b1, 4);

        set_vals(8'h30, 8'h6A, 8'h11, 8'h15, 8'h07, 8'h24);
`ifdef RTC_WR_BCD_CHECK_EN
        seg_in = vals[0]; min_in = vals[1]; hora_in = vals[2];
        dia_in = vals[3]; mes_in = vals[4]; ano_in = vals[5];
        en_clk = 1'b1;
        start  = 1'b1;
        tick(0, 0, 0);
        start = 1'b0;
        check("bcd_err", err, 1);
        check("bcd_e_write", e_write, 0);
        check("bcd_bus", bus_data, 8'hFF);
        tick(1, 0, 0);
        check("bcd_err_clear", err, 0);
        check("bcd_no_bus", bus_data, 8'hFF);
        check("bcd_no_e_write", e_write, 0);
        tick(0, 0, 0);
`else
        run_seq(1'b1, -1);
`endif

        for (int iter = 0; iter < 20; iter++) begin
            set_vals(rand_bcd(), rand_bcd(), rand_bcd(), rand_bcd(), rand_bcd(), rand_bcd());
            run_seq(1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 2)) begin
                tick(0, 0, 0);
                check("idle_e_write", e_write, 0);
                check("idle_bus", bus_data, 8'hFF);
            end
        end

        tick(0, 0, 0);
        check("done_count", done_seen, done_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
